// File: rtl/bus_width_pkg.sv
// Shared types and helpers for the bus width downsizer: FSM state encoding
// and beat-pointer width calculation.
package bus_width_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    BUSY  = 1'b1
  } state_t;

  // A one-bit pointer is still needed when the ratio is 2 or less.
  function automatic int ptr_width(input int ratio);
    return (ratio > 2) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/bus_width_downsizer.sv
// Splits each SIZE_IN-bit word into SIZE_IN/SIZE_OUT narrow beats, MSB or LSB slice first.
// Optional out_last port is built when BUS_WIDTH_DOWNSIZER_LAST_EN is defined.
module bus_width_downsizer
  import bus_width_pkg::*;
#(
  parameter int SIZE_IN    = 32,
  parameter int SIZE_OUT   = 8,
  parameter int BIG_ENDIAN = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SIZE_IN-1:0]  in,
  output logic                out_valid,
  input  logic                out_ready,
`ifdef BUS_WIDTH_DOWNSIZER_LAST_EN
  output logic                out_last,
`endif
  output logic [SIZE_OUT-1:0] out
);

  localparam int RATIO = SIZE_IN / SIZE_OUT;
  localparam int PTR_W = ptr_width(RATIO);
  localparam logic [PTR_W-1:0] LAST_K = PTR_W'(RATIO - 1);

  if ((SIZE_IN % SIZE_OUT) != 0 || RATIO < 2) begin : g_bad_ratio
    $error("bus_width_downsizer: SIZE_IN must be a multiple of SIZE_OUT with ratio >= 2");
  end

  state_t             state, state_n;
  logic [PTR_W-1:0]   k, k_n;
  logic [SIZE_IN-1:0] word, word_n;
  logic [PTR_W-1:0]   sel;
  logic               last_beat;

  assign last_beat = (k == LAST_K);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      k     <= '0;
      word  <= '0;
    end else begin
      state <= state_n;
      k     <= k_n;
      word  <= word_n;
    end
  end

  always_comb begin
    state_n   = state;
    k_n       = k;
    word_n    = word;
    out_valid = 1'b0;
    in_ready  = 1'b0;
    case (state)
      EMPTY: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_n = BUSY;
          k_n     = '0;
          word_n  = in;
        end
      end
      BUSY: begin
        out_valid = 1'b1;
        in_ready  = last_beat && out_ready;
        if (out_ready) begin
          if (!last_beat) begin
            k_n = k + PTR_W'(1);
          end else if (in_valid) begin
            // Reload on the last beat so words stream without a bubble.
            k_n    = '0;
            word_n = in;
          end else begin
            state_n = EMPTY;
            k_n     = '0;
          end
        end
      end
      default: begin
        state_n = EMPTY;
        k_n     = '0;
      end
    endcase
  end

  assign sel = (BIG_ENDIAN != 0) ? (LAST_K - k) : k;

  always_comb begin
    out = '0;
    for (int j = 0; j < RATIO; j++) begin
      if (sel == PTR_W'(j)) out = word[j*SIZE_OUT +: SIZE_OUT];
    end
  end

`ifdef BUS_WIDTH_DOWNSIZER_LAST_EN
  assign out_last = out_valid && last_beat;
`endif

endmodule

// File: tb/tb_bus_width_downsizer.sv
// Directed, table-driven bench for bus_width_downsizer: big-endian 32->8,
// little-endian 32->8 and a ratio-3 24->8 instance, plus reset corner cases.
module tb_bus_width_downsizer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic [2:0]  in_valid;
  logic [2:0]  out_ready;
  logic [2:0]  in_ready;
  logic [2:0]  out_valid;
  logic [2:0]  out_last;
  logic [7:0]  out_be, out_le, out_r3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bus_width_downsizer #(.SIZE_IN(32), .SIZE_OUT(8), .BIG_ENDIAN(1)) dut_be (
    .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in(in_data), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
`ifdef BUS_WIDTH_DOWNSIZER_LAST_EN
    .out_last(out_last[0]),
`endif
    .out(out_be));

  bus_width_downsizer #(.SIZE_IN(32), .SIZE_OUT(8), .BIG_ENDIAN(0)) dut_le (
    .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in(in_data), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
`ifdef BUS_WIDTH_DOWNSIZER_LAST_EN
    .out_last(out_last[1]),
`endif
    .out(out_le));

  bus_width_downsizer #(.SIZE_IN(24), .SIZE_OUT(8), .BIG_ENDIAN(1)) dut_r3 (
    .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in(in_data[23:0]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
`ifdef BUS_WIDTH_DOWNSIZER_LAST_EN
    .out_last(out_last[2]),
`endif
    .out(out_r3));

`ifndef BUS_WIDTH_DOWNSIZER_LAST_EN
  assign out_last = 3'b000;
`endif

  typedef struct {
    int         sel;
    logic       iv;
    logic [31:0] din;
    logic       ordy;
    logic       e_ov;
    logic [7:0] e_out;
    logic       e_ir;
    logic       e_last;
    logic       chk_out;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int s, input logic iv, input logic [31:0] d, input logic ordy,
                     input logic ov, input logic [7:0] o, input logic ir, input logic lst,
                     input logic co);
    vec_t v;
    v.sel = s; v.iv = iv; v.din = d; v.ordy = ordy;
    v.e_ov = ov; v.e_out = o; v.e_ir = ir; v.e_last = lst; v.chk_out = co;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] out_of(input int s);
    case (s)
      0:       return out_be;
      1:       return out_le;
      default: return out_r3;
    endcase
  endfunction

  task automatic drive(input int s, input logic iv, input logic [31:0] d, input logic ordy);
    in_valid  = 3'b000;
    out_ready = 3'b111;
    in_valid[s]  = iv;
    out_ready[s] = ordy;
    in_data = d;
  endtask

  task automatic check_row(input int r, input vec_t v);
    string tag;
    tag = $sformatf("row%0d_dut%0d", r, v.sel);
    chk({tag, "_out_valid"}, {31'd0, out_valid[v.sel]}, {31'd0, v.e_ov});
    chk({tag, "_in_ready"}, {31'd0, in_ready[v.sel]}, {31'd0, v.e_ir});
    if (v.chk_out) chk({tag, "_out"}, {24'd0, out_of(v.sel)}, {24'd0, v.e_out});
`ifdef BUS_WIDTH_DOWNSIZER_LAST_EN
    chk({tag, "_out_last"}, {31'd0, out_last[v.sel]}, {31'd0, v.e_last});
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // big-endian single word, then back-to-back, then stalls
    add(0, 0, 32'h0, 1, 0, 8'h00, 1, 0, 1);
    add(0, 1, 32'hAABBCCDD, 1, 0, 8'h00, 1, 0, 0);
    add(0, 0, 32'h0, 1, 1, 8'hAA, 0, 0, 1);
    add(0, 0, 32'h0, 1, 1, 8'hBB, 0, 0, 1);
    add(0, 0, 32'h0, 1, 1, 8'hCC, 0, 0, 1);
    add(0, 0, 32'h0, 1, 1, 8'hDD, 1, 1, 1);
    add(0, 1, 32'h11223344, 1, 0, 8'h00, 1, 0, 0);
    add(0, 1, 32'h55667788, 1, 1, 8'h11, 0, 0, 1);
    add(0, 1, 32'h55667788, 1, 1, 8'h22, 0, 0, 1);
    add(0, 1, 32'h55667788, 1, 1, 8'h33, 0, 0, 1);
    add(0, 1, 32'h55667788, 1, 1, 8'h44, 1, 1, 1);
    add(0, 0, 32'h0, 1, 1, 8'h55, 0, 0, 1);
    add(0, 0, 32'h0, 1, 1, 8'h66, 0, 0, 1);
    add(0, 0, 32'h0, 1, 1, 8'h77, 0, 0, 1);
    add(0, 0, 32'h0, 1, 1, 8'h88, 1, 1, 1);
    add(0, 1, 32'hAABBCCDD, 1, 0, 8'h00, 1, 0, 0);
    add(0, 0, 32'h0, 1, 1, 8'hAA, 0, 0, 1);
    add(0, 1, 32'hDEADBEEF, 0, 1, 8'hBB, 0, 0, 1);
    add(0, 1, 32'hDEADBEEF, 0, 1, 8'hBB, 0, 0, 1);
    add(0, 0, 32'h0, 1, 1, 8'hBB, 0, 0, 1);
    add(0, 0, 32'h0, 1, 1, 8'hCC, 0, 0, 1);
    add(0, 1, 32'hDEADBEEF, 0, 1, 8'hDD, 0, 1, 1);
    add(0, 0, 32'h0, 1, 1, 8'hDD, 1, 1, 1);
    add(0, 0, 32'h0, 1, 0, 8'h00, 1, 0, 0);
    // little-endian
    add(1, 1, 32'hAABBCCDD, 1, 0, 8'h00, 1, 0, 0);
    add(1, 0, 32'h0, 1, 1, 8'hDD, 0, 0, 1);
    add(1, 0, 32'h0, 1, 1, 8'hCC, 0, 0, 1);
    add(1, 0, 32'h0, 1, 1, 8'hBB, 0, 0, 1);
    add(1, 0, 32'h0, 1, 1, 8'hAA, 1, 1, 1);
    add(1, 0, 32'h0, 1, 0, 8'h00, 1, 0, 0);
    // ratio 3: pointer must wrap at 2
    add(2, 1, 32'h00123456, 1, 0, 8'h00, 1, 0, 0);
    add(2, 0, 32'h0, 1, 1, 8'h12, 0, 0, 1);
    add(2, 0, 32'h0, 1, 1, 8'h34, 0, 0, 1);
    add(2, 1, 32'h00ABCDEF, 1, 1, 8'h56, 1, 1, 1);
    add(2, 0, 32'h0, 1, 1, 8'hAB, 0, 0, 1);
    add(2, 0, 32'h0, 1, 1, 8'hCD, 0, 0, 1);
    add(2, 0, 32'h0, 1, 1, 8'hEF, 1, 1, 1);
    add(2, 0, 32'h0, 1, 0, 8'h00, 1, 0, 0);
    add(2, 0, 32'h0, 1, 0, 8'h00, 1, 0, 0);

    reset = 1'b1;
    drive(0, 0, 32'h0, 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int r = 0; r < tbl.size(); r++) begin
      if (r != 0) @(negedge clk);
      drive(tbl[r].sel, tbl[r].iv, tbl[r].din, tbl[r].ordy);
      #1;
      check_row(r, tbl[r]);
    end

    // reset mid-word on big-endian while little-endian sees a handshake
    @(negedge clk); drive(0, 1, 32'hAABBCCDD, 1); #1;
    chk("rst_load_ready", {31'd0, in_ready[0]}, 32'd1);
    @(negedge clk); drive(0, 0, 32'h0, 1); #1;
    chk("rst_beat_aa", {24'd0, out_be}, 32'hAA);
    @(negedge clk); #1;
    chk("rst_beat_bb", {24'd0, out_be}, 32'hBB);
    @(negedge clk);
    reset = 1'b1;
    in_valid = 3'b010; out_ready = 3'b111; in_data = 32'h11111111;
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 32'h0, 1);
    #1;
    chk("rst_be_out_valid", {31'd0, out_valid[0]}, 32'd0);
    chk("rst_be_out", {24'd0, out_be}, 32'h0);
    chk("rst_be_in_ready", {31'd0, in_ready[0]}, 32'd1);
    chk("rst_le_out_valid", {31'd0, out_valid[1]}, 32'd0);
    chk("rst_le_in_ready", {31'd0, in_ready[1]}, 32'd1);
    chk("rst_last", {29'd0, out_last}, 32'd0);
    @(negedge clk); drive(0, 1, 32'h11223344, 1); #1;
    chk("post_rst_ready", {31'd0, in_ready[0]}, 32'd1);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk); drive(0, 0, 32'h0, 1); #1;
      chk($sformatf("post_rst_beat%0d_valid", b), {31'd0, out_valid[0]}, 32'd1);
      chk($sformatf("post_rst_beat%0d", b), {24'd0, out_be}, 32'h11 * (b + 1));
    end
    @(negedge clk); #1;
    chk("post_rst_empty", {31'd0, out_valid[0]}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
